// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit.
// Op codes, FSM states and the op field width.
package mdu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] MDOP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MDOP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MDOP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MDOP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MDOP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MDOP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Divide step only exists when MDU_DIV_EN is defined.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_o;

  // acc = {partial product, remaining multiplier bits}
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
          + {1'b0, (acc_i[0] ? opnd_i : '0)};
    mul_o = {sum, acc_i[WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [2*WIDTH-1:0] div_o;

  // acc = {remainder, dividend bits / quotient bits}
  always_comb begin
    rem_ext = acc_i[2*WIDTH-1:WIDTH-1];
    ge      = rem_ext >= {1'b0, opnd_i};
    diff    = rem_ext - {1'b0, opnd_i};
    div_o   = {(ge ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0]),
               acc_i[WIDTH-2:0], ge};
    acc_o   = mode ? div_o : mul_o;
  end
`else
  always_comb begin
    acc_o = mode ? acc_i : mul_o;
  end
`endif

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/DIV unit with HI/LO registers, WIDTH+1 cycle latency.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU are NOPs.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               is_mul, is_dv, go, sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] step_acc, prod;

`ifdef MDU_DIV_EN
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   quo, rem;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mode   (is_div(op_q)),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    is_mul = start && (op == MDOP_MULT || op == MDOP_MULTU);
`ifdef MDU_DIV_EN
    is_dv  = start && is_div(op);
`else
    is_dv  = 1'b0;
`endif
    go     = (state_q == IDLE) && (is_mul || is_dv);
    sgn    = (op == MDOP_MULT) || (op == MDOP_DIV);
    mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
    mag_b  = (sgn && b[WIDTH-1]) ? -b : b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d   = op_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
`ifdef MDU_DIV_EN
    bz_d   = bz_q;
    quo    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
    unique case (state_q)
      IDLE: begin
        if (go) begin
          op_d   = op;
          sa_d   = sgn && a[WIDTH-1];
          sb_d   = sgn && b[WIDTH-1];
          acc_d  = {{WIDTH{1'b0}}, mag_a};
          opnd_d = mag_b;
          cnt_d  = CW'(WIDTH);
`ifdef MDU_DIV_EN
          bz_d   = (b == '0);
`endif
        end else if (start && op == MDOP_MTHI) begin
          hi_d = a;
        end else if (start && op == MDOP_MTLO) begin
          lo_d = a;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
        done_d = 1'b1;
        hi_d   = prod[2*WIDTH-1:WIDTH];
        lo_d   = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div(op_q)) begin
          hi_d = rem;
          lo_d = bz_q ? '1 : quo;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      acc_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bz_q <= 1'b0;
    else        bz_q <= bz_d;
  end
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
